// File: rtl/bus_timer_if.sv
`default_nettype none
// ============================================================================
// bus_timer_if : system-bus slave slot signals for the interval timer
// Revision     : 1.0
// ============================================================================
interface bus_timer_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 2
);
  logic                  cs_;
  logic                  as_;
  logic                  rw;
  logic [REG_ADDR_W-1:0] addr;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W-1:0]     rd_data;
  logic                  rdy_;
  logic                  irq;

  modport master (
    output cs_, as_, rw, addr, wr_data,
    input  rd_data, rdy_, irq
  );

  modport slave (
    input  cs_, as_, rw, addr, wr_data,
    output rd_data, rdy_, irq
  );
endinterface
`default_nettype wire

// File: rtl/bus_timer.sv
`default_nettype none
// ============================================================================
// bus_timer : programmable interval timer, one-shot or periodic level irq
// Revision  : 1.0
// ============================================================================
module bus_timer #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 2
) (
  input  wire        clk,
  input  wire        reset_,
  bus_timer_if.slave bus
);

  localparam logic [REG_ADDR_W-1:0] c_addr_ctrl    = REG_ADDR_W'(0);
  localparam logic [REG_ADDR_W-1:0] c_addr_intr    = REG_ADDR_W'(1);
  localparam logic [REG_ADDR_W-1:0] c_addr_expire  = REG_ADDR_W'(2);
  localparam logic [REG_ADDR_W-1:0] c_addr_counter = REG_ADDR_W'(3);

  logic              r_start;
  logic              r_periodic;
  logic              r_intr;
  logic [DATA_W-1:0] r_expire;
  logic [DATA_W-1:0] r_counter;
  logic              r_resp;
  logic [DATA_W-1:0] r_rd_data;

  logic              w_access;
  logic              w_write;
  logic              w_wr_ctrl;
  logic              w_wr_intr;
  logic              w_wr_expire;
  logic              w_wr_counter;
  logic              w_expiry;
  logic [DATA_W-1:0] w_rd_mux;
  logic [DATA_W-1:0] w_counter_nxt;
  logic              w_start_nxt;
  logic              w_intr_nxt;

  assign w_access     = !bus.cs_ && !bus.as_;
  assign w_write      = w_access && !bus.rw;
  assign w_wr_ctrl    = w_write && (bus.addr == c_addr_ctrl);
  assign w_wr_intr    = w_write && (bus.addr == c_addr_intr);
  assign w_wr_expire  = w_write && (bus.addr == c_addr_expire);
  assign w_wr_counter = w_write && (bus.addr == c_addr_counter);

  assign w_expiry = r_start && (r_counter == r_expire);

  // Read data is the pre-edge register image, so a read in an expiry or
  // write cycle returns the value the register held before that edge.
  always_comb begin
    w_rd_mux = '0;
    case (bus.addr)
      c_addr_ctrl:    w_rd_mux = {{(DATA_W-2){1'b0}}, r_periodic, r_start};
      c_addr_intr:    w_rd_mux = {{(DATA_W-1){1'b0}}, r_intr};
      c_addr_expire:  w_rd_mux = r_expire;
      c_addr_counter: w_rd_mux = r_counter;
      default:        w_rd_mux = '0;
    endcase
  end

  // Priority: bus writes beat the timer's own updates, except that an
  // expiry always leaves the interrupt flag set.
  always_comb begin
    w_counter_nxt = r_counter;
    if (w_wr_counter) begin
      w_counter_nxt = bus.wr_data;
    end else if (w_expiry) begin
      w_counter_nxt = '0;
    end else if (r_start) begin
      w_counter_nxt = r_counter + DATA_W'(1);
    end

    w_start_nxt = r_start;
    if (w_wr_ctrl) begin
      w_start_nxt = bus.wr_data[0];
    end else if (w_expiry && !r_periodic) begin
      w_start_nxt = 1'b0;
    end

    w_intr_nxt = r_intr;
    if (w_expiry) begin
      w_intr_nxt = 1'b1;
    end else if (w_wr_intr && !bus.wr_data[0]) begin
      w_intr_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_start    <= 1'b0;
      r_periodic <= 1'b0;
      r_intr     <= 1'b0;
      r_expire   <= '0;
      r_counter  <= '0;
    end else begin
      r_start   <= w_start_nxt;
      r_intr    <= w_intr_nxt;
      r_counter <= w_counter_nxt;
      if (w_wr_ctrl) begin
        r_periodic <= bus.wr_data[1];
      end
      if (w_wr_expire) begin
        r_expire <= bus.wr_data;
      end
    end
  end

  // One response cycle per accepted strobe; read data is zero otherwise.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_resp    <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_resp    <= w_access;
      r_rd_data <= (w_access && bus.rw) ? w_rd_mux : '0;
    end
  end

  assign bus.rdy_    = !r_resp;
  assign bus.rd_data = r_rd_data;
  assign bus.irq     = r_intr;

endmodule
`default_nettype wire
